// File: rtl/ram_2port_chk_ctrl_pkg.sv
// rtl/ram_2port_chk_ctrl_pkg.sv - shared FSM encoding and read-latency limits
package ram_2port_chk_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Out-of-range latencies fall back to the nearest legal value.
  function automatic int legal_rd_lat(input int lat);
    return (lat >= RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT_MIN;
  endfunction

endpackage

// File: rtl/ram_2port_sdp.sv
// rtl/ram_2port_sdp.sv - inferred simple dual-port RAM, port A write, port B read
// Read latency 1 (registered read) or 2 (extra output register).
module ram_2port_sdp #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
  end

  // Only the read registers reset; array contents survive reset.
  always_ff @(posedge clk_i) begin
    if (rst_i)        rd_q <= '0;
    else if (rd_en_i) rd_q <= mem[rd_addr_i];
  end

  if (RD_LAT >= 2) begin : g_oreg
    logic [DATA_W-1:0] out_q;
    always_ff @(posedge clk_i) begin
      if (rst_i) out_q <= '0;
      else       out_q <= rd_q;
    end
    assign rd_data_o = out_q;
  end else begin : g_noreg
    assign rd_data_o = rd_q;
  end

endmodule

// File: rtl/ram_2port_chk_ctrl.sv
// rtl/ram_2port_chk_ctrl.sv - write/read-back self-check controller around a dual-port RAM
// Optional: RAM_CHK_LOOP_EN repeats passes with an incrementing seed until a stop request.
module ram_2port_chk_ctrl
  import ram_2port_chk_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32,
  parameter int RD_LAT = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic [DATA_W-1:0] pat_seed,
  input  logic              inj_en,
  input  logic [ADDR_W-1:0] inj_addr,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] rd_data_dbg
`ifdef RAM_CHK_LOOP_EN
  ,
  output logic [15:0]       pass_cnt
`endif
);

  localparam int LAT = legal_rd_lat(RD_LAT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   ERR_MAX   = (ADDR_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              drain_q, drain_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic              inj_en_q, inj_en_d;
  logic [ADDR_W-1:0] inj_addr_q, inj_addr_d;
  logic [ADDR_W:0]   err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic              pass_q, pass_d;
  logic              wr_en, rd_en, clr_errs, start_acc;
  logic              inj_hit, mismatch;
  logic [DATA_W-1:0] pat, wr_data, ram_rd_data;

  logic [DATA_W-1:0] exp_q   [LAT];
  logic [ADDR_W-1:0] eaddr_q [LAT];
  logic [LAT-1:0]    vld_q;

`ifdef RAM_CHK_LOOP_EN
  logic        stop_q, stop_d;
  logic [15:0] pass_cnt_q, pass_cnt_d;
`endif

  assign pat     = seed_q + DATA_W'(addr_q);
  assign inj_hit = inj_en_q && (addr_q == inj_addr_q);
  assign wr_data = pat ^ DATA_W'(inj_hit);

  ram_2port_sdp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .RD_LAT (LAT)
  ) u_ram (
    .clk_i     (sys_clk),
    .rst_i     (sys_rst),
    .wr_en_i   (wr_en),
    .wr_addr_i (addr_q),
    .wr_data_i (wr_data),
    .rd_en_i   (rd_en),
    .rd_addr_i (addr_q),
    .rd_data_o (ram_rd_data)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    drain_d    = drain_q;
    seed_d     = seed_q;
    inj_en_d   = inj_en_q;
    inj_addr_d = inj_addr_q;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    clr_errs   = 1'b0;
    start_acc  = 1'b0;
`ifdef RAM_CHK_LOOP_EN
    stop_d     = stop_q;
    pass_cnt_d = pass_cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_WRITE;
          addr_d     = '0;
          seed_d     = pat_seed;
          inj_en_d   = inj_en;
          inj_addr_d = inj_addr;
          clr_errs   = 1'b1;
          start_acc  = 1'b1;
`ifdef RAM_CHK_LOOP_EN
          stop_d     = 1'b0;
`endif
        end
      end
      ST_WRITE: begin
        wr_en = 1'b1;
        if (addr_q == LAST_ADDR) begin
          state_d = ST_READ;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      ST_READ: begin
        rd_en = 1'b1;
        if (addr_q == LAST_ADDR) begin
          state_d = ST_DRAIN;
          addr_d  = '0;
          drain_d = 1'b0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_q == 1'(LAT - 1)) state_d = ST_DONE;
        else                        drain_d = 1'b1;
      end
      ST_DONE: begin
`ifdef RAM_CHK_LOOP_EN
        pass_cnt_d = pass_cnt_q + 1'b1;
        stop_d     = 1'b0;
        if (stop_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d  = ST_WRITE;
          addr_d   = '0;
          seed_d   = seed_q + 1'b1;
          clr_errs = 1'b1;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef RAM_CHK_LOOP_EN
    if (start && busy) stop_d = 1'b1;
`endif
  end

  // Compare lines up with the RAM output exactly LAT cycles after issue.
  assign mismatch = vld_q[LAT-1] && (ram_rd_data != exp_q[LAT-1]);

  always_comb begin
    err_cnt_d = err_cnt_q;
    first_d   = first_q;
    pass_d    = pass_q;
    if (clr_errs) begin
      err_cnt_d = '0;
      first_d   = '0;
    end else if (mismatch) begin
      if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + 1'b1;
      if (err_cnt_q == '0)      first_d   = eaddr_q[LAT-1];
    end
    if (start_acc)
      pass_d = 1'b0;
    else if (state_q == ST_DRAIN && state_d == ST_DONE)
      pass_d = (err_cnt_d == '0);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      drain_q    <= 1'b0;
      seed_q     <= '0;
      inj_en_q   <= 1'b0;
      inj_addr_q <= '0;
      err_cnt_q  <= '0;
      first_q    <= '0;
      pass_q     <= 1'b0;
      vld_q[0]   <= 1'b0;
      exp_q[0]   <= '0;
      eaddr_q[0] <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      drain_q    <= drain_d;
      seed_q     <= seed_d;
      inj_en_q   <= inj_en_d;
      inj_addr_q <= inj_addr_d;
      err_cnt_q  <= err_cnt_d;
      first_q    <= first_d;
      pass_q     <= pass_d;
      vld_q[0]   <= rd_en;
      exp_q[0]   <= pat;
      eaddr_q[0] <= addr_q;
    end
  end

  for (genvar g = 1; g < LAT; g++) begin : g_stage
    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        vld_q[g]   <= 1'b0;
        exp_q[g]   <= '0;
        eaddr_q[g] <= '0;
      end else begin
        vld_q[g]   <= vld_q[g-1];
        exp_q[g]   <= exp_q[g-1];
        eaddr_q[g] <= eaddr_q[g-1];
      end
    end
  end

`ifdef RAM_CHK_LOOP_EN
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      stop_q     <= 1'b0;
      pass_cnt_q <= '0;
    end else begin
      stop_q     <= stop_d;
      pass_cnt_q <= pass_cnt_d;
    end
  end
  assign pass_cnt = pass_cnt_q;
`endif

  assign busy           = (state_q == ST_WRITE) || (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign done           = (state_q == ST_DONE);
  assign pass           = pass_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_q;
  assign rd_data_dbg    = ram_rd_data;

endmodule

// File: tb/tb_ram_2port_chk_ctrl.sv
// tb/tb_ram_2port_chk_ctrl.sv - directed table-driven bench for ram_2port_chk_ctrl
module tb_ram_2port_chk_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start0, start1;
  logic [7:0] seed0, seed1;
  logic       inj0, inj1;
  logic [4:0] ia0, ia1;
  logic       busy0, done0, pass0, busy1, done1, pass1;
  logic [5:0] err0, err1;
  logic [4:0] first0, first1;
  logic [7:0] rd0, rd1;
`ifdef RAM_CHK_LOOP_EN
  logic [15:0] pcnt0, pcnt1;
`endif

  int checks = 0;
  int errors = 0;
  int sel = 0;

  always #5 clk = ~clk;

  ram_2port_chk_ctrl #(.DATA_W(8), .ADDR_W(5), .DEPTH(32), .RD_LAT(1)) u_dut (
    .sys_clk(clk), .sys_rst(rst), .start(start0), .pat_seed(seed0), .inj_en(inj0),
    .inj_addr(ia0), .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
    .first_err_addr(first0), .rd_data_dbg(rd0)
`ifdef RAM_CHK_LOOP_EN
    , .pass_cnt(pcnt0)
`endif
  );

  ram_2port_chk_ctrl #(.DATA_W(8), .ADDR_W(5), .DEPTH(16), .RD_LAT(2)) u_dut2 (
    .sys_clk(clk), .sys_rst(rst), .start(start1), .pat_seed(seed1), .inj_en(inj1),
    .inj_addr(ia1), .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
    .first_err_addr(first1), .rd_data_dbg(rd1)
`ifdef RAM_CHK_LOOP_EN
    , .pass_cnt(pcnt1)
`endif
  );

  logic       busy_m, done_m, pass_m;
  logic [5:0] err_m;
  logic [4:0] first_m;
  logic [7:0] rd_m;

  always_comb begin
    busy_m  = (sel != 0) ? busy1  : busy0;
    done_m  = (sel != 0) ? done1  : done0;
    pass_m  = (sel != 0) ? pass1  : pass0;
    err_m   = (sel != 0) ? err1   : err0;
    first_m = (sel != 0) ? first1 : first0;
    rd_m    = (sel != 0) ? rd1    : rd0;
  end

  typedef struct {
    int         sel;
    logic [7:0] seed;
    logic       inj;
    logic [4:0] ia;
    int         exp_err;
    int         exp_first;
    logic       exp_pass;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int depth, lat, cyc, mism, k, exp_done;
    bit got;
    logic [7:0] exp_rd;
    sel      = v.sel;
    depth    = (v.sel != 0) ? 16 : 32;
    lat      = (v.sel != 0) ? 2 : 1;
    exp_done = 2 * depth + lat + 1;
    @(negedge clk);
    if (v.sel == 0) begin seed0 = v.seed; inj0 = v.inj; ia0 = v.ia; start0 = 1'b1; end
    else            begin seed1 = v.seed; inj1 = v.inj; ia1 = v.ia; start1 = 1'b1; end
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    cyc = 0; got = 0; mism = 0;
    while (!got && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk($sformatf("v%0d_busy_c1", idx), 64'(busy_m), 64'd1);
      if (cyc >= depth + 1 + lat && cyc <= 2 * depth + lat) begin
        k = cyc - depth - 1 - lat;
        exp_rd = v.seed + 8'(k);
        if (v.inj && k == int'(v.ia)) exp_rd = exp_rd ^ 8'h01;
        if (rd_m !== exp_rd) mism++;
      end
      if (done_m) got = 1;
    end
    chk($sformatf("v%0d_done_cycle", idx), 64'(got ? cyc : -1), 64'(exp_done));
    chk($sformatf("v%0d_busy_at_done", idx), 64'(busy_m), 64'd0);
    chk($sformatf("v%0d_err_cnt", idx), 64'(err_m), 64'(v.exp_err));
    chk($sformatf("v%0d_first_err_addr", idx), 64'(first_m), 64'(v.exp_first));
    chk($sformatf("v%0d_pass", idx), 64'(pass_m), 64'(v.exp_pass));
    chk($sformatf("v%0d_rd_data_dbg_seq", idx), 64'(mism), 64'd0);
    @(negedge clk);
    chk($sformatf("v%0d_done_pulse", idx), 64'(done_m), 64'd0);
    chk($sformatf("v%0d_pass_held", idx), 64'(pass_m), 64'(v.exp_pass));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, ndone, d1, d2;
    vecs[0] = '{0, 8'h00, 1'b0, 5'd0,  0, 0,  1'b1};
    vecs[1] = '{0, 8'hF0, 1'b0, 5'd0,  0, 0,  1'b1};
    vecs[2] = '{0, 8'h10, 1'b1, 5'd7,  1, 7,  1'b0};
    vecs[3] = '{0, 8'hAA, 1'b0, 5'd7,  0, 0,  1'b1};
    vecs[4] = '{0, 8'h00, 1'b1, 5'd0,  1, 0,  1'b0};
    vecs[5] = '{0, 8'hFF, 1'b1, 5'd31, 1, 31, 1'b0};
    vecs[6] = '{1, 8'h00, 1'b1, 5'd15, 1, 15, 1'b0};
    vecs[7] = '{1, 8'hA5, 1'b0, 5'd0,  0, 0,  1'b1};

    rst = 1'b1;
    start0 = 1'b0; seed0 = '0; inj0 = 1'b0; ia0 = '0;
    start1 = 1'b0; seed1 = '0; inj1 = 1'b0; ia1 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs0", {busy0, done0, pass0, err0, first0, rd0}, '0);
    chk("reset_outputs1", {busy1, done1, pass1, err1, first1, rd1}, '0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Reset asserted during cycle 20 of a run: outputs clear next cycle, no done.
    sel = 0;
    @(negedge clk);
    seed0 = 8'h33; inj0 = 1'b0; start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    for (int c = 1; c <= 20; c++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrun_reset_outputs", {busy0, done0, pass0, err0, first0, rd0}, '0);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done0) ndone++;
    end
    chk("midrun_reset_no_done", 64'(ndone), 64'd0);
    run_vec(vecs[1], 8);

    // Start pulse while busy is ignored: one done at the normal cycle.
    @(negedge clk);
    seed0 = 8'h01; inj0 = 1'b0; start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    ndone = 0; d1 = -1;
    for (cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (cyc == 10) start0 = 1'b1;
      if (cyc == 11) start0 = 1'b0;
      if (done0) begin
        ndone++;
        if (d1 < 0) d1 = cyc;
      end
    end
    chk("busy_start_done_cycle", 64'(d1), 64'd66);
    chk("busy_start_single_done", 64'(ndone), 64'd1);

    // Start held high re-triggers from IDLE on the cycle after done.
    @(negedge clk);
    seed0 = 8'h40; inj0 = 1'b0; start0 = 1'b1;
    @(posedge clk);
    ndone = 0; d1 = -1; d2 = -1;
    for (cyc = 1; cyc <= 220; cyc++) begin
      @(negedge clk);
      if (done0) begin
        ndone++;
        if (d1 < 0) d1 = cyc;
        else if (d2 < 0) begin
          d2 = cyc;
          start0 = 1'b0;
        end
      end
    end
    start0 = 1'b0;
    chk("retrigger_first_done", 64'(d1), 64'd66);
    chk("retrigger_second_done", 64'(d2), 64'd133);
    chk("retrigger_done_count", 64'(ndone), 64'd2);
    chk("retrigger_pass", 64'(pass0), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
